// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter with pending-write scoreboard
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] RDaddr,
    output logic [DATA_W-1:0] RDdata
);

    localparam int NREG = 1 << ADDR_W;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              last_grant_q, last_grant_d;
    logic [NREG-1:0]   pending_q, pending_d;

    logic              pick0;
    logic              grant0, grant1, xfer;
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    // Grant selection: req0 wins a tie when fixed priority or when req1 was served last.
    // Grants are held off during reset so no handshake appears to complete while state is cleared.
    always_comb begin
        pick0     = (RR_EN == 1'b0) ? 1'b1 : last_grant_q;
        grant0    = !rst && req0_valid && (!req1_valid || pick0);
        grant1    = !rst && req1_valid && !(req0_valid && pick0);
        xfer      = grant0 || grant1;
        xfer_addr = grant1 ? req1_addr : req0_addr;
        xfer_data = grant1 ? req1_data : req0_data;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Next-state for the write output, round-robin pointer and scoreboard.
    always_comb begin
        reg_write_d  = xfer && (xfer_addr != '0);
        rd_addr_d    = reg_write_d ? xfer_addr : rd_addr_q;
        rd_data_d    = reg_write_d ? xfer_data : rd_data_q;
        last_grant_d = xfer ? grant1 : last_grant_q;
        pending_d    = pending_q;
        if (xfer) begin
            pending_d[xfer_addr] = 1'b0;
        end
        // A reservation is the younger producer, so it overrides a same-cycle clear.
        if (rsv_valid && (rsv_addr != '0)) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // State registers; reset dominates any concurrent request or reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            last_grant_q <= 1'b1;
            pending_q    <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
        end
    end

    assign RegWrite = reg_write_q;
    assign RDaddr   = rd_addr_q;
    assign RDdata   = rd_data_q;
    assign rs_busy  = pending_q[rs_addr];
    assign rt_busy  = pending_q[rt_addr];

endmodule
